// File: rtl/bcd_serial_subtractor.sv
// Digit-serial packed-BCD subtractor: A - B one digit per clock, LSD first,
// returning sign plus BCD magnitude (a second serial pass complements negative results).
module bcd_serial_subtractor #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   diff,
  output logic                  neg,
  output logic                  invalid,
  output logic [1:0]            state_dbg
);

  // Handshake: start is sampled only on an edge where busy=0; done is a
  // one-cycle pulse with busy=0, so start may be reasserted in that cycle.

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t          state;
  logic [W-1:0]    a_sh;
  logic [W-1:0]    b_sh;
  logic [W-1:0]    res;
  logic            borrow;
  logic [CW-1:0]   cnt;

  logic            any_bad;
  logic [4:0]      t;
  logic [3:0]      digit;
  logic            borrow_nxt;
  logic [W+3:0]    res_wide;
  logic [W-1:0]    res_nxt;

  assign state_dbg = state;

  always_comb begin
    any_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) any_bad = 1'b1;
    end
  end

  // Both passes share this digit slice; FIX feeds it minuend 0, subtrahend r.
  always_comb begin
    t          = {1'b0, a_sh[3:0]} - {1'b0, b_sh[3:0]} - {4'd0, borrow};
    borrow_nxt = t[4];
    digit      = t[4] ? (t[3:0] + 4'd10) : t[3:0];
    res_wide   = {digit, res};
    res_nxt    = res_wide[W+3:4];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= '0;
      neg     <= 1'b0;
      invalid <= 1'b0;
      a_sh    <= '0;
      b_sh    <= '0;
      res     <= '0;
      borrow  <= 1'b0;
      cnt     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            borrow <= 1'b0;
            cnt    <= '0;
            if (any_bad) begin
              done    <= 1'b1;
              invalid <= 1'b1;
              diff    <= '0;
              neg     <= 1'b0;
            end else begin
              state <= SUB;
              busy  <= 1'b1;
            end
          end
        end
        SUB: begin
          a_sh   <= a_sh >> 4;
          b_sh   <= b_sh >> 4;
          res    <= res_nxt;
          borrow <= borrow_nxt;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            cnt <= '0;
            if (!borrow_nxt) begin
              state   <= IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
              diff    <= res_nxt;
              neg     <= 1'b0;
              invalid <= 1'b0;
            end else begin
              state  <= FIX;
              a_sh   <= '0;
              b_sh   <= res_nxt;
              borrow <= 1'b0;
            end
          end
        end
        FIX: begin
          a_sh   <= a_sh >> 4;
          b_sh   <= b_sh >> 4;
          res    <= res_nxt;
          borrow <= borrow_nxt;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            // The final borrow is the complement's carry-out and carries no information.
            cnt     <= '0;
            borrow  <= 1'b0;
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
            diff    <= res_nxt;
            neg     <= 1'b1;
            invalid <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Self-checking bench for bcd_serial_subtractor (DIGITS=4): directed vector table,
// hand-written multi-cycle sequences and random operands checked against a decimal model.
module tb_bcd_serial_subtractor;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          busy, done, neg, invalid;
  logic [W-1:0]  diff;
  logic [1:0]    state_dbg;

  int total = 0;
  int bad   = 0;

  bcd_serial_subtractor #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .neg(neg),
    .invalid(invalid), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         neg;
    logic         inv;
    int           lat;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // Reference model: plain decimal arithmetic on the operand values.
  function automatic bit has_bad(input logic [W-1:0] v);
    bit r = 0;
    for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) r = 1;
    return r;
  endfunction

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic vec_t model(input logic [W-1:0] ma, input logic [W-1:0] mb);
    vec_t v;
    int   av, bv;
    v.a = ma;
    v.b = mb;
    if (has_bad(ma) || has_bad(mb)) begin
      v.diff = '0; v.neg = 1'b0; v.inv = 1'b1; v.lat = 0;
    end else begin
      av = bcd2int(ma);
      bv = bcd2int(mb);
      v.neg  = (av < bv);
      v.diff = int2bcd(av < bv ? bv - av : av - bv);
      v.inv  = 1'b0;
      v.lat  = (av < bv) ? 2 * DIGITS : DIGITS;
    end
    return v;
  endfunction

  // Lat counts edges after the capture edge before done is seen.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL done_timeout: got=no done expected=done within 40 cycles");
    end
  endtask

  task automatic capture(input logic [W-1:0] ta, input logic [W-1:0] tb_v);
    @(negedge clk);
    a = ta; b = tb_v; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int lat;
    capture(v.a, v.b);
    check({tag, "_busy_after_capture"}, busy, v.inv ? 0 : 1);
    wait_done(lat);
    check({tag, "_latency"}, lat, v.lat);
    check({tag, "_diff"}, diff, v.diff);
    check({tag, "_neg"}, neg, v.neg);
    check({tag, "_invalid"}, invalid, v.inv);
    check({tag, "_busy_in_done"}, busy, 0);
    @(posedge clk); #1;
    check({tag, "_done_one_cycle"}, done, 0);
  endtask

  initial begin
    int lat, cnt;
    vec_t v;

    vecs[0] = '{16'h5432, 16'h1234, 16'h4198, 1'b0, 1'b0, 4};
    vecs[1] = '{16'h1234, 16'h5432, 16'h4198, 1'b1, 1'b0, 8};
    vecs[2] = '{16'h1000, 16'h0001, 16'h0999, 1'b0, 1'b0, 4};
    vecs[3] = '{16'h0000, 16'h0001, 16'h0001, 1'b1, 1'b0, 8};
    vecs[4] = '{16'h9999, 16'h9999, 16'h0000, 1'b0, 1'b0, 4};
    vecs[5] = '{16'h12A4, 16'h0000, 16'h0000, 1'b0, 1'b1, 0};
    vecs[6] = '{16'h0000, 16'h9999, 16'h9999, 1'b1, 1'b0, 8};
    vecs[7] = '{16'h0500, 16'h0500, 16'h0000, 1'b0, 1'b0, 4};

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_neg", neg, 0);
    check("rst_invalid", invalid, 0);
    check("rst_state", state_dbg, 0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Back-to-back: new start in the done cycle; operands scrambled after capture.
    capture(16'h1000, 16'h0001);
    wait_done(lat);
    check("b2b_first_diff", diff, 16'h0999);
    a = 16'h0010; b = 16'h0005; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 16'h9999; b = 16'h0000;
    check("b2b_busy", busy, 1);
    wait_done(lat);
    check("b2b_latency", lat, 4);
    check("b2b_diff", diff, 16'h0005);
    check("b2b_neg", neg, 0);

    // A start pulse mid-operation is ignored and produces no extra done.
    capture(16'h5432, 16'h1234);
    @(negedge clk); a = 16'h0000; b = 16'h0001; start = 1'b1;
    @(negedge clk); start = 1'b0;
    #1;
    wait_done(lat);
    check("midstart_diff", diff, 16'h4198);
    check("midstart_neg", neg, 0);
    cnt = 0;
    repeat (12) begin @(posedge clk); #1; if (done) cnt++; end
    check("midstart_no_extra_done", cnt, 0);

    // Reset two cycles into a negative operation.
    capture(16'h1234, 16'h5432);
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_diff", diff, 0);
    check("midrst_neg", neg, 0);
    check("midrst_state", state_dbg, 0);
    @(negedge clk); rst = 1'b0;
    cnt = 0;
    repeat (15) begin @(posedge clk); #1; if (done || busy) cnt++; end
    check("midrst_quiet", cnt, 0);

    // Reset and start together: reset wins.
    @(negedge clk); rst = 1'b1; start = 1'b1; a = 16'h0001; b = 16'h0000;
    @(posedge clk); #1;
    check("rst_start_busy", busy, 0);
    @(negedge clk); rst = 1'b0; start = 1'b0;

    // Random operands against the decimal model, sometimes equal or malformed.
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      for (int d = 0; d < DIGITS; d++) begin
        ra[4*d +: 4] = 4'($urandom_range(0, 9));
        rb[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 7) == 0) rb = ra;
      if ($urandom_range(0, 9) == 0) ra[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
      v = model(ra, rb);
      run_vec($sformatf("rnd%0d", i), v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
